// File: rtl/pc_gen_mc.sv
// -----------------------------------------------------------------------------
// pc_gen_mc -- fetch-PC generator with a valid/ready handshake toward fetch.
//
// After reset it waits BOOT_DELAY cycles, then presents one fetch address per
// cycle. pc_o advances by INST_BYTES on each accepted fetch (pc_valid_o &
// fetch_allow_in_i). A redirect replaces the next PC. Redirect channels are
// priority-encoded, and channel 0 has the highest priority. halt_i parks the
// generator with pc_valid_o low until halt_i drops or a redirect arrives.
//
// Optional feature macro: PC_MISALIGN_EN
//   When PC_MISALIGN_EN is defined, a redirect target with nonzero low
//   log2(INST_BYTES) bits is loaded with those bits cleared, and misalign_o
//   pulses for one cycle. When it is undefined, the target is loaded
//   unmodified and misalign_o is tied to 0.
//
// Ports
//   clk_i            in   clock
//   rst              in   synchronous, active-high reset
//   redir_valid_i    in   [NUM_REDIR]  per-channel redirect request
//   redir_pc_i       in   [NUM_REDIR*PC_WIDTH]  channel k at [k*PC_WIDTH +: PC_WIDTH]
//   halt_i           in   level, requests fetch stop (WFI)
//   fetch_allow_in_i in   fetch stage ready
//   pc_valid_o       out  pc_o holds a valid fetch address
//   pc_o             out  [PC_WIDTH] current fetch PC
//   redir_sel_o      out  [NUM_REDIR] one-hot of the winning redirect (combinational)
//   flush_o          out  registered 1-cycle pulse after a redirect is applied
//   misalign_o       out  registered 1-cycle pulse after a misaligned redirect
// -----------------------------------------------------------------------------
module pc_gen_mc #(
    parameter int unsigned           PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = PC_WIDTH'(32'h8000_0000),
    parameter int unsigned           NUM_REDIR  = 3,
    parameter int unsigned           INST_BYTES = 4,
    parameter int unsigned           BOOT_DELAY = 2
) (
    input  logic                          clk_i,
    input  logic                          rst,
    input  logic [NUM_REDIR-1:0]          redir_valid_i,
    input  logic [NUM_REDIR*PC_WIDTH-1:0] redir_pc_i,
    input  logic                          halt_i,
    input  logic                          fetch_allow_in_i,
    output logic                          pc_valid_o,
    output logic [PC_WIDTH-1:0]           pc_o,
    output logic [NUM_REDIR-1:0]          redir_sel_o,
    output logic                          flush_o,
    output logic                          misalign_o
);

    localparam int unsigned CNT_W = (BOOT_DELAY > 0) ? $clog2(BOOT_DELAY + 1) : 1;
    localparam logic [PC_WIDTH-1:0] INC        = PC_WIDTH'(INST_BYTES);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INST_BYTES - 1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    boot_cnt;
    logic [PC_WIDTH-1:0] pc_q;
    logic                valid_q;
    logic                flush_q;

    logic                redir_any;
    logic [PC_WIDTH-1:0] redir_target;
    logic [PC_WIDTH-1:0] load_pc;

    // Priority encoder. The scan runs from the highest index down, so the last
    // hit, which is the lowest asserted index, wins.
    // NOTE: every always_comb output gets a default before any conditional
    // assignment; otherwise paths that skip the assignment infer a latch.
    always_comb begin
        redir_sel_o  = '0;
        redir_target = '0;
        for (int k = int'(NUM_REDIR) - 1; k >= 0; k--) begin
            if (redir_valid_i[k]) begin
                redir_sel_o    = '0;
                redir_sel_o[k] = 1'b1;
                redir_target   = redir_pc_i[k*PC_WIDTH +: PC_WIDTH];
            end
        end
    end

    assign redir_any = |redir_valid_i;

`ifdef PC_MISALIGN_EN
    logic target_misaligned;
    logic misalign_q;

    assign target_misaligned = |(redir_target & ALIGN_MASK);
    assign load_pc           = redir_target & ~ALIGN_MASK;

    always_ff @(posedge clk_i) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= redir_any & target_misaligned;
    end

    assign misalign_o = misalign_q;
`else
    assign load_pc    = redir_target;
    assign misalign_o = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so that every
    // right-hand side reads the value from before the clock edge.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state    <= ST_BOOT;
            boot_cnt <= CNT_W'(BOOT_DELAY);
            pc_q     <= RESET_PC;
            valid_q  <= (BOOT_DELAY == 0);
            flush_q  <= 1'b0;
        end else begin
            flush_q <= redir_any;

            // A redirect overrides both the increment and any stall. An
            // accepted fetch advances the PC even when halt_i is also
            // being requested.
            if (redir_any) begin
                pc_q <= load_pc;
            end else if (valid_q && fetch_allow_in_i) begin
                pc_q <= pc_q + INC;
            end

            case (state)
                ST_BOOT: begin
                    // Leave BOOT on the edge where the count reaches zero, so
                    // that pc_valid_o stays low for exactly BOOT_DELAY cycles.
                    if (boot_cnt <= CNT_W'(1)) begin
                        state    <= ST_RUN;
                        valid_q  <= 1'b1;
                        boot_cnt <= '0;
                    end else begin
                        boot_cnt <= boot_cnt - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (halt_i && !redir_any) begin
                        state   <= ST_HALT;
                        valid_q <= 1'b0;
                    end
                end
                ST_HALT: begin
                    // A redirect wakes the generator even if halt_i is still high.
                    if (redir_any || !halt_i) begin
                        state   <= ST_RUN;
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_RUN;
                    valid_q <= 1'b1;
                end
            endcase
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = valid_q;
    assign flush_o    = flush_q;

endmodule

// File: tb/tb_pc_gen_mc.sv
// -----------------------------------------------------------------------------
// tb_pc_gen_mc -- self-checking bench for pc_gen_mc at its default parameters.
// A behavioural model tracks the boot countdown, the halted flag and the
// expected PC. A directed sequence runs first, followed by random stimulus.
// -----------------------------------------------------------------------------
module tb_pc_gen_mc;

    localparam int W  = 32;
    localparam int NR = 3;
    localparam int BOOT_DELAY = 2;
    localparam logic [W-1:0] RESET_PC = 32'h8000_0000;

    logic            clk_i = 1'b0;
    logic            rst   = 1'b1;
    logic [NR-1:0]   redir_valid_i = '0;
    logic [NR*W-1:0] redir_pc_i    = '0;
    logic            halt_i        = 1'b0;
    logic            fetch_allow_in_i = 1'b0;
    logic            pc_valid_o;
    logic [W-1:0]    pc_o;
    logic [NR-1:0]   redir_sel_o;
    logic            flush_o;
    logic            misalign_o;

    pc_gen_mc dut (
        .clk_i            (clk_i),
        .rst              (rst),
        .redir_valid_i    (redir_valid_i),
        .redir_pc_i       (redir_pc_i),
        .halt_i           (halt_i),
        .fetch_allow_in_i (fetch_allow_in_i),
        .pc_valid_o       (pc_valid_o),
        .pc_o             (pc_o),
        .redir_sel_o      (redir_sel_o),
        .flush_o          (flush_o),
        .misalign_o       (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Behavioural reference state.
    int           m_boot_left;
    bit           m_halted;
    logic [W-1:0] m_pc;
    bit           m_valid;
    bit           m_flush;
    bit           m_mis;

    // Applies one cycle of stimulus. The task is entered just after a falling
    // edge. It checks the combinational select, advances the model across the
    // rising edge, and checks the registered outputs at the next falling edge.
    task automatic step(input bit r, input logic [NR-1:0] rv,
                        input logic [W-1:0] t0, input logic [W-1:0] t1,
                        input logic [W-1:0] t2, input bit h, input bit a);
        logic [W-1:0] tgt [NR];
        int           win;
        logic [NR-1:0] exp_sel;
        tgt[0] = t0; tgt[1] = t1; tgt[2] = t2;
        rst = r; redir_valid_i = rv; redir_pc_i = {t2, t1, t0};
        halt_i = h; fetch_allow_in_i = a;

        win = -1;
        for (int i = 0; i < NR; i++) if (rv[i] && win < 0) win = i;
        exp_sel = '0;
        if (win >= 0) exp_sel = NR'(1 << win);
        #1;
        check("redir_sel", 64'(redir_sel_o), 64'(exp_sel));

        if (r) begin
            m_pc = RESET_PC; m_boot_left = BOOT_DELAY; m_halted = 0;
            m_valid = (BOOT_DELAY == 0); m_flush = 0; m_mis = 0;
        end else begin
            m_flush = (win >= 0);
            m_mis   = 0;
            if (win >= 0) begin
`ifdef PC_MISALIGN_EN
                m_mis = (tgt[win] % 4) != 0;
                m_pc  = tgt[win] - (tgt[win] % 4);
`else
                m_pc  = tgt[win];
`endif
            end else if (m_valid && a) begin
                m_pc = m_pc + 32'd4;
            end
            if (m_boot_left > 0) begin
                m_boot_left--;
                if (m_boot_left == 0) m_valid = 1;
            end else if (m_halted) begin
                if (win >= 0 || !h) begin m_halted = 0; m_valid = 1; end
            end else if (h && win < 0) begin
                m_halted = 1; m_valid = 0;
            end
        end

        @(posedge clk_i);
        @(negedge clk_i);
        check("pc",       64'(pc_o),       64'(m_pc));
        check("valid",    64'(pc_valid_o), 64'(m_valid));
        check("flush",    64'(flush_o),    64'(m_flush));
        check("misalign", 64'(misalign_o), 64'(m_mis));
    endtask

    // Shorthand for a cycle with no redirect.
    task automatic idle(input bit h, input bit a);
        step(0, '0, '0, '0, '0, h, a);
    endtask

    initial begin
        @(negedge clk_i);
        // 1: reset, boot delay, then sequential fetch.
        step(1, '0, '0, '0, '0, 0, 1);
        check("t1_rst_pc", 64'(pc_o), 64'h8000_0000);
        check("t1_rst_valid", 64'(pc_valid_o), 64'h0);
        idle(0, 1);
        check("t1_boot_valid", 64'(pc_valid_o), 64'h0);
        idle(0, 1);
        check("t1_pc0", 64'(pc_o), 64'h8000_0000);
        check("t1_valid", 64'(pc_valid_o), 64'h1);
        idle(0, 1);
        check("t1_pc1", 64'(pc_o), 64'h8000_0004);
        idle(0, 1);
        check("t1_pc2", 64'(pc_o), 64'h8000_0008);
        idle(0, 1);
        idle(0, 1);
        check("t2_at10", 64'(pc_o), 64'h8000_0010);

        // 2: stall for three cycles, then release.
        for (int i = 0; i < 3; i++) begin
            idle(0, 0);
            check("t2_stall_pc", 64'(pc_o), 64'h8000_0010);
            check("t2_stall_valid", 64'(pc_valid_o), 64'h1);
        end
        idle(0, 1);
        check("t2_release", 64'(pc_o), 64'h8000_0014);

        // 3: channel 1 beats channel 2 and overrides the stall.
        step(0, 3'b110, 32'h0, 32'h0000_1000, 32'h0000_2000, 0, 0);
        check("t3_pc", 64'(pc_o), 64'h0000_1000);
        check("t3_flush", 64'(flush_o), 64'h1);
        idle(0, 0);
        check("t3_flush_end", 64'(flush_o), 64'h0);

        // 4: halt, then wake with a redirect while halt_i is still high.
        step(0, 3'b001, 32'h8000_0020, 32'h0, 32'h0, 0, 0);
        idle(1, 0);
        check("t4_halt_valid", 64'(pc_valid_o), 64'h0);
        check("t4_halt_pc", 64'(pc_o), 64'h8000_0020);
        idle(1, 1);
        check("t4_hold_pc", 64'(pc_o), 64'h8000_0020);
        step(0, 3'b001, 32'h8000_0100, 32'h0, 32'h0, 1, 1);
        check("t4_wake_pc", 64'(pc_o), 64'h8000_0100);
        check("t4_wake_valid", 64'(pc_valid_o), 64'h1);

        // 5: wrap-around, then a reset mid-stream beats a redirect.
        step(0, 3'b100, 32'h0, 32'h0, 32'hFFFF_FFFC, 0, 0);
        idle(0, 1);
        check("t5_wrap", 64'(pc_o), 64'h0000_0000);
        step(1, 3'b001, 32'h1234_5678, 32'h0, 32'h0, 1, 1);
        check("t5_rst_pc", 64'(pc_o), 64'h8000_0000);
        check("t5_rst_valid", 64'(pc_valid_o), 64'h0);
        idle(0, 1);
        idle(0, 1);

        // 6: misaligned redirect target.
        step(0, 3'b010, 32'h0, 32'h0000_1002, 32'h0, 0, 0);
`ifdef PC_MISALIGN_EN
        check("t6_pc", 64'(pc_o), 64'h0000_1000);
        check("t6_mis", 64'(misalign_o), 64'h1);
`else
        check("t6_pc", 64'(pc_o), 64'h0000_1002);
        check("t6_mis", 64'(misalign_o), 64'h0);
`endif
        idle(0, 0);

        // Random stimulus against the model.
        for (int n = 0; n < 400; n++) begin
            logic [NR-1:0] rv;
            rv = '0;
            for (int i = 0; i < NR; i++) rv[i] = ($urandom_range(0, 7) == 0);
            step(($urandom_range(0, 63) == 0), rv, $urandom, $urandom, $urandom,
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
